pipe_ctrl_unit: RTL and testbench

- Next-generation pipelined MIPS control unit.
- Decodes the ID-stage opcode into EX/MEM/WB control bundles and carries them, with destination-register tags, through the ID/EX, EX/MEM and MEM/WB registers.
- Adds load-use and branch/jump hazard control (stall, bubble, flush), resolution of EX-stage beq/bne, an addi opcode, and saturating stall/flush counters.
- Sits between IF/ID and the datapath pipeline registers.

---
 rtl/pipe_ctrl_unit_if.sv | 57 +++++
 rtl/pipe_ctrl_unit.sv | 271 +++++++++++++++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_unit_if.sv
// pipe_ctrl_unit_if
//   Bundles the ID-stage decode inputs and all control/tag/counter outputs of
//   the pipelined MIPS control unit.
//   slave  : control-unit side (drives pc/ifid controls, stage controls, tags,
//            forwarding selects and performance counters)
//   master : datapath side (drives the ID opcode/register fields and ex_zero)
//   Parameters: OP_W opcode width, REG_W register-address width,
//               CNT_W performance counter width.
interface pipe_ctrl_unit_if #(
    parameter int unsigned OP_W  = 6,
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 16
);
    // Datapath -> control
    logic [OP_W-1:0]  id_op;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic [REG_W-1:0] id_rd;
    logic             ex_zero;

    // Control -> datapath
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             pc_src_branch;
    logic             pc_src_jump;
    logic             ex_regdst;
    logic             ex_alusrc;
    logic [1:0]       ex_aluop;
    logic             mem_read;
    logic             mem_write;
    logic             wb_memtoreg;
    logic             wb_regwrite;
    logic [REG_W-1:0] ex_dest;
    logic [REG_W-1:0] mem_dest;
    logic [REG_W-1:0] wb_dest;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_op, id_rs, id_rt, id_rd, ex_zero,
        input  pc_write, ifid_write, ifid_flush, pc_src_branch, pc_src_jump,
        input  ex_regdst, ex_alusrc, ex_aluop, mem_read, mem_write,
        input  wb_memtoreg, wb_regwrite, ex_dest, mem_dest, wb_dest,
        input  fwd_a, fwd_b, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_op, id_rs, id_rt, id_rd, ex_zero,
        output pc_write, ifid_write, ifid_flush, pc_src_branch, pc_src_jump,
        output ex_regdst, ex_alusrc, ex_aluop, mem_read, mem_write,
        output wb_memtoreg, wb_regwrite, ex_dest, mem_dest, wb_dest,
        output fwd_a, fwd_b, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit
//   Pipelined MIPS control unit. Decodes the ID opcode into EX/MEM/WB control
//   bundles, carries them with destination tags through ID/EX, EX/MEM and
//   MEM/WB, resolves EX-stage beq/bne, and generates stall/bubble/flush for
//   load-use and branch/jump hazards. Saturating stall and flush counters.
//   Ports:
//     clk   : rising-edge clock
//     reset : asynchronous active-high reset
//     bus   : pipe_ctrl_unit_if.slave (ID fields, ex_zero in; PC/IF-ID
//             controls, stage controls, tags, forwarding selects, counters out)
//   Build option:
//     PIPE_CTRL_FORWARD_EN defined   -> forwarding unit drives fwd_a/fwd_b.
//     PIPE_CTRL_FORWARD_EN undefined -> fwd_a/fwd_b are 00 and any RAW
//       dependence on EX or MEM stalls instead (WB writes before RF read).
module pipe_ctrl_unit #(
    parameter int unsigned OP_W  = 6,
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 16
) (
    input logic             clk,
    input logic             reset,
    pipe_ctrl_unit_if.slave bus
);

    localparam logic [OP_W-1:0] OP_R    = OP_W'(6'h00);
    localparam logic [OP_W-1:0] OP_J    = OP_W'(6'h02);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'h04);
    localparam logic [OP_W-1:0] OP_BNE  = OP_W'(6'h05);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'h08);
    localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'h23);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'h2B);

    typedef struct packed {
        logic       regdst;
        logic       alusrc;
        logic [1:0] aluop;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regwrite;
        logic       beq;
        logic       bne;
    } ctrl_t;

    // ------------------------------------------------------------------
    // ID decode
    // ------------------------------------------------------------------
    ctrl_t            id_ctrl;
    logic             id_jump;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic [REG_W-1:0] id_dest;

    always_comb begin
        id_ctrl = '0;
        id_jump = 1'b0;
        case (bus.id_op)
            OP_R: begin
                id_ctrl.regdst   = 1'b1;
                id_ctrl.regwrite = 1'b1;
                id_ctrl.aluop    = 2'b10;
            end
            OP_LW: begin
                id_ctrl.alusrc   = 1'b1;
                id_ctrl.memread  = 1'b1;
                id_ctrl.memtoreg = 1'b1;
                id_ctrl.regwrite = 1'b1;
            end
            OP_SW: begin
                id_ctrl.alusrc   = 1'b1;
                id_ctrl.memwrite = 1'b1;
            end
            OP_ADDI: begin
                id_ctrl.alusrc   = 1'b1;
                id_ctrl.regwrite = 1'b1;
            end
            OP_BEQ: begin
                id_ctrl.beq   = 1'b1;
                id_ctrl.aluop = 2'b01;
            end
            OP_BNE: begin
                id_ctrl.bne   = 1'b1;
                id_ctrl.aluop = 2'b01;
            end
            OP_J:    id_jump = 1'b1;
            default: ;
        endcase
        id_dest = id_ctrl.regdst ? bus.id_rd : bus.id_rt;
        // r0 is hard-wired: never mark it as written, so it never forwards/stalls
        if (id_dest == '0) begin
            id_ctrl.regwrite = 1'b0;
        end
        id_uses_rs = ~id_jump;
        id_uses_rt = (bus.id_op == OP_R) | (bus.id_op == OP_SW) |
                     (bus.id_op == OP_BEQ) | (bus.id_op == OP_BNE);
    end

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    ctrl_t            ex_ctrl_q, ex_ctrl_d;
    logic [REG_W-1:0] ex_dest_q, ex_dest_d;
    logic             mem_memread_q, mem_memwrite_q, mem_memtoreg_q, mem_regwrite_q;
    logic [REG_W-1:0] mem_dest_q;
    logic             wb_memtoreg_q, wb_regwrite_q;
    logic [REG_W-1:0] wb_dest_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // True when a producer (dest/we) feeds a register the ID instruction reads.
    function automatic logic reads_dest(input logic [REG_W-1:0] dest,
                                        input logic             we,
                                        input logic             use_rs,
                                        input logic             use_rt,
                                        input logic [REG_W-1:0] rs,
                                        input logic [REG_W-1:0] rt);
        return we && (dest != '0) &&
               ((use_rs && (dest == rs)) || (use_rt && (dest == rt)));
    endfunction

    logic br_taken;
    logic load_use;
    logic hazard;

    assign br_taken = (ex_ctrl_q.beq & bus.ex_zero) | (ex_ctrl_q.bne & ~bus.ex_zero);
    assign load_use = reads_dest(ex_dest_q, ex_ctrl_q.memread, id_uses_rs, id_uses_rt,
                                 bus.id_rs, bus.id_rt);

`ifdef PIPE_CTRL_FORWARD_EN
    assign hazard = load_use;
`else
    assign hazard = load_use |
                    reads_dest(ex_dest_q, ex_ctrl_q.regwrite, id_uses_rs, id_uses_rt,
                               bus.id_rs, bus.id_rt) |
                    reads_dest(mem_dest_q, mem_regwrite_q, id_uses_rs, id_uses_rt,
                               bus.id_rs, bus.id_rt);
`endif

    // ------------------------------------------------------------------
    // Hazard / PC control (taken branch > hazard > jump > normal)
    // ------------------------------------------------------------------
    logic pc_write, ifid_write, ifid_flush, pc_src_branch, pc_src_jump;
    logic bubble, stall;

    always_comb begin
        pc_write      = 1'b1;
        ifid_write    = 1'b1;
        ifid_flush    = 1'b0;
        pc_src_branch = 1'b0;
        pc_src_jump   = 1'b0;
        bubble        = 1'b0;
        stall         = 1'b0;
        if (reset) begin
            // hold the documented reset values even if ID shows a jump
        end else if (br_taken) begin
            pc_src_branch = 1'b1;
            ifid_flush    = 1'b1;
            bubble        = 1'b1;
        end else if (hazard) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            bubble     = 1'b1;
            stall      = 1'b1;
        end else if (id_jump) begin
            pc_src_jump = 1'b1;
            ifid_flush  = 1'b1;
            bubble      = 1'b1;
        end
    end

    always_comb begin
        ex_ctrl_d   = bubble ? '0 : id_ctrl;
        ex_dest_d   = bubble ? '0 : id_dest;
        stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
        flush_cnt_d = (ifid_flush && (flush_cnt_q != '1)) ? flush_cnt_q + 1'b1 : flush_cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_ctrl_q      <= '0;
            ex_dest_q      <= '0;
            mem_memread_q  <= 1'b0;
            mem_memwrite_q <= 1'b0;
            mem_memtoreg_q <= 1'b0;
            mem_regwrite_q <= 1'b0;
            mem_dest_q     <= '0;
            wb_memtoreg_q  <= 1'b0;
            wb_regwrite_q  <= 1'b0;
            wb_dest_q      <= '0;
            stall_cnt_q    <= '0;
            flush_cnt_q    <= '0;
        end else begin
            ex_ctrl_q      <= ex_ctrl_d;
            ex_dest_q      <= ex_dest_d;
            mem_memread_q  <= ex_ctrl_q.memread;
            mem_memwrite_q <= ex_ctrl_q.memwrite;
            mem_memtoreg_q <= ex_ctrl_q.memtoreg;
            mem_regwrite_q <= ex_ctrl_q.regwrite;
            mem_dest_q     <= ex_dest_q;
            wb_memtoreg_q  <= mem_memtoreg_q;
            wb_regwrite_q  <= mem_regwrite_q;
            wb_dest_q      <= mem_dest_q;
            stall_cnt_q    <= stall_cnt_d;
            flush_cnt_q    <= flush_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Forwarding
    // ------------------------------------------------------------------
`ifdef PIPE_CTRL_FORWARD_EN
    logic [REG_W-1:0] ex_rs_q, ex_rs_d;
    logic [REG_W-1:0] ex_rt_q, ex_rt_d;

    assign ex_rs_d = bubble ? '0 : bus.id_rs;
    assign ex_rt_d = bubble ? '0 : bus.id_rt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_rs_q <= '0;
            ex_rt_q <= '0;
        end else begin
            ex_rs_q <= ex_rs_d;
            ex_rt_q <= ex_rt_d;
        end
    end

    // EX/MEM result is newer than MEM/WB, so it wins.
    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src,
                                           input logic             m_we,
                                           input logic [REG_W-1:0] m_dest,
                                           input logic             w_we,
                                           input logic [REG_W-1:0] w_dest);
        if (m_we && (m_dest != '0) && (m_dest == src)) begin
            return 2'b10;
        end
        if (w_we && (w_dest != '0) && (w_dest == src)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    assign bus.fwd_a = fwd_sel(ex_rs_q, mem_regwrite_q, mem_dest_q, wb_regwrite_q, wb_dest_q);
    assign bus.fwd_b = fwd_sel(ex_rt_q, mem_regwrite_q, mem_dest_q, wb_regwrite_q, wb_dest_q);
`else
    assign bus.fwd_a = '0;
    assign bus.fwd_b = '0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.pc_write      = pc_write;
    assign bus.ifid_write    = ifid_write;
    assign bus.ifid_flush    = ifid_flush;
    assign bus.pc_src_branch = pc_src_branch;
    assign bus.pc_src_jump   = pc_src_jump;
    assign bus.ex_regdst     = ex_ctrl_q.regdst;
    assign bus.ex_alusrc     = ex_ctrl_q.alusrc;
    assign bus.ex_aluop      = ex_ctrl_q.aluop;
    assign bus.mem_read      = mem_memread_q;
    assign bus.mem_write     = mem_memwrite_q;
    assign bus.wb_memtoreg   = wb_memtoreg_q;
    assign bus.wb_regwrite   = wb_regwrite_q;
    assign bus.ex_dest       = ex_dest_q;
    assign bus.mem_dest      = mem_dest_q;
    assign bus.wb_dest       = wb_dest_q;
    assign bus.stall_cnt     = stall_cnt_q;
    assign bus.flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb_pipe_ctrl_unit
//   Directed bench for pipe_ctrl_unit (CNT_W=4 so saturation is reachable).
//   Expected values track the PIPE_CTRL_FORWARD_EN build option.
module tb_pipe_ctrl_unit;
    localparam int unsigned OP_W  = 6;
    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl_unit_if #(.OP_W(OP_W), .REG_W(REG_W), .CNT_W(CNT_W)) bus ();

    pipe_ctrl_unit #(.OP_W(OP_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [5:0] op;
        logic [4:0] rs, rt, rd;
        logic [3:0] ex;    // {regdst, alusrc, aluop}
        logic [1:0] mem;   // {mem_read, mem_write}
        logic [1:0] wb;    // {wb_memtoreg, wb_regwrite}
        logic [4:0] dest;
    } vec_t;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_id(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic z);
        bus.id_op   = op;
        bus.id_rs   = rs;
        bus.id_rt   = rt;
        bus.id_rd   = rd;
        bus.ex_zero = z;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_id(6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        tick(2);
        #2 reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_id(6'h02, 5'd0, 5'd0, 5'd0, 1'b0);
        tick(1);
        checks++;
        if ({bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.pc_src_branch, bus.pc_src_jump} !== 5'b11000) begin
            errors++;
            $display("FAIL reset_pc_ctrl got %b want 11000",
                     {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.pc_src_branch, bus.pc_src_jump});
        end
        checks++;
        if ({bus.ex_dest, bus.mem_dest, bus.wb_dest} !== 15'd0) begin
            errors++;
            $display("FAIL reset_tags got %h want 0", {bus.ex_dest, bus.mem_dest, bus.wb_dest});
        end
        checks++;
        if ({bus.ex_regdst, bus.ex_alusrc, bus.ex_aluop, bus.mem_read, bus.mem_write,
             bus.wb_memtoreg, bus.wb_regwrite} !== 8'd0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 0", {bus.ex_regdst, bus.ex_alusrc, bus.ex_aluop,
                     bus.mem_read, bus.mem_write, bus.wb_memtoreg, bus.wb_regwrite});
        end
        checks++;
        if ({bus.stall_cnt, bus.flush_cnt, bus.fwd_a, bus.fwd_b} !== 12'd0) begin
            errors++;
            $display("FAIL reset_cnt_fwd got %h want 0", {bus.stall_cnt, bus.flush_cnt, bus.fwd_a, bus.fwd_b});
        end
        #2 reset = 1'b0;
    endtask

    task automatic test_decode();
        vec_t v[7];
        v[0] = '{6'h00, 5'd1, 5'd2, 5'd3, 4'b1010, 2'b00, 2'b01, 5'd3}; // add r3,r1,r2
        v[1] = '{6'h23, 5'd1, 5'd5, 5'd0, 4'b0100, 2'b10, 2'b11, 5'd5}; // lw r5
        v[2] = '{6'h2B, 5'd1, 5'd6, 5'd0, 4'b0100, 2'b01, 2'b00, 5'd6}; // sw r6
        v[3] = '{6'h08, 5'd1, 5'd7, 5'd0, 4'b0100, 2'b00, 2'b01, 5'd7}; // addi r7
        v[4] = '{6'h04, 5'd1, 5'd2, 5'd0, 4'b0001, 2'b00, 2'b00, 5'd2}; // beq (not taken)
        v[5] = '{6'h00, 5'd1, 5'd2, 5'd0, 4'b1010, 2'b00, 2'b00, 5'd0}; // add r0 -> no regwrite
        v[6] = '{6'h3F, 5'd1, 5'd9, 5'd9, 4'b0000, 2'b00, 2'b00, 5'd9}; // unknown
        do_reset();
        for (int i = 0; i < 7; i++) begin
            set_id(v[i].op, v[i].rs, v[i].rt, v[i].rd, 1'b0);
            checks++;
            if ({bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.pc_src_branch, bus.pc_src_jump} !== 5'b11000) begin
                errors++;
                $display("FAIL decode%0d_pc got %b want 11000", i,
                         {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.pc_src_branch, bus.pc_src_jump});
            end
            tick(1);
            set_id(6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
            checks++;
            if ({bus.ex_regdst, bus.ex_alusrc, bus.ex_aluop, bus.ex_dest} !== {v[i].ex, v[i].dest}) begin
                errors++;
                $display("FAIL decode%0d_ex got %b want %b", i,
                         {bus.ex_regdst, bus.ex_alusrc, bus.ex_aluop, bus.ex_dest}, {v[i].ex, v[i].dest});
            end
            tick(1);
            checks++;
            if ({bus.mem_read, bus.mem_write, bus.mem_dest} !== {v[i].mem, v[i].dest}) begin
                errors++;
                $display("FAIL decode%0d_mem got %b want %b", i,
                         {bus.mem_read, bus.mem_write, bus.mem_dest}, {v[i].mem, v[i].dest});
            end
            tick(1);
            checks++;
            if ({bus.wb_memtoreg, bus.wb_regwrite, bus.wb_dest} !== {v[i].wb, v[i].dest}) begin
                errors++;
                $display("FAIL decode%0d_wb got %b want %b", i,
                         {bus.wb_memtoreg, bus.wb_regwrite, bus.wb_dest}, {v[i].wb, v[i].dest});
            end
        end
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(6'h23, 5'd1, 5'd2, 5'd0, 1'b0);   // lw r2,0(r1)
        tick(1);
        set_id(6'h00, 5'd2, 5'd4, 5'd3, 1'b0);   // add r3,r2,r4
        checks++;
        if ({bus.pc_write, bus.ifid_write} !== 2'b00) begin
            errors++;
            $display("FAIL lu_stall got %b want 00", {bus.pc_write, bus.ifid_write});
        end
        tick(1);
        checks++;
        if ({bus.ex_dest, bus.mem_dest, bus.stall_cnt} !== {5'd0, 5'd2, 4'd1}) begin
            errors++;
            $display("FAIL lu_bubble got %h want %h", {bus.ex_dest, bus.mem_dest, bus.stall_cnt},
                     {5'd0, 5'd2, 4'd1});
        end
`ifdef PIPE_CTRL_FORWARD_EN
        checks++;
        if ({bus.pc_write, bus.ifid_write} !== 2'b11) begin
            errors++;
            $display("FAIL lu_release got %b want 11", {bus.pc_write, bus.ifid_write});
        end
        tick(1);
        checks++;
        if ({bus.ex_dest, bus.fwd_a, bus.fwd_b, bus.stall_cnt} !== {5'd3, 2'b01, 2'b00, 4'd1}) begin
            errors++;
            $display("FAIL lu_fwd got %h want %h", {bus.ex_dest, bus.fwd_a, bus.fwd_b, bus.stall_cnt},
                     {5'd3, 2'b01, 2'b00, 4'd1});
        end
`else
        checks++;
        if ({bus.pc_write, bus.ifid_write} !== 2'b00) begin
            errors++;
            $display("FAIL lu_mem_stall got %b want 00", {bus.pc_write, bus.ifid_write});
        end
        tick(1);
        checks++;
        if ({bus.pc_write, bus.ifid_write, bus.wb_dest, bus.stall_cnt} !== {2'b11, 5'd2, 4'd2}) begin
            errors++;
            $display("FAIL lu_release got %h want %h", {bus.pc_write, bus.ifid_write, bus.wb_dest, bus.stall_cnt},
                     {2'b11, 5'd2, 4'd2});
        end
        tick(1);
        checks++;
        if ({bus.ex_dest, bus.fwd_a, bus.fwd_b, bus.stall_cnt} !== {5'd3, 2'b00, 2'b00, 4'd2}) begin
            errors++;
            $display("FAIL lu_enter got %h want %h", {bus.ex_dest, bus.fwd_a, bus.fwd_b, bus.stall_cnt},
                     {5'd3, 2'b00, 2'b00, 4'd2});
        end
`endif
    endtask

    task automatic test_forward();
        do_reset();
        set_id(6'h00, 5'd1, 5'd2, 5'd5, 1'b0);   // add r5,r1,r2
        tick(1);
        set_id(6'h00, 5'd1, 5'd2, 5'd5, 1'b0);   // add r5,r1,r2
        tick(1);
        set_id(6'h00, 5'd5, 5'd5, 5'd6, 1'b0);   // add r6,r5,r5
`ifdef PIPE_CTRL_FORWARD_EN
        tick(1);
        checks++;
        if ({bus.ex_dest, bus.fwd_a, bus.fwd_b} !== {5'd6, 2'b10, 2'b10}) begin
            errors++;
            $display("FAIL fwd_priority got %h want %h", {bus.ex_dest, bus.fwd_a, bus.fwd_b},
                     {5'd6, 2'b10, 2'b10});
        end
`else
        checks++;
        if ({bus.pc_write, bus.ifid_write} !== 2'b00) begin
            errors++;
            $display("FAIL raw_ex_stall got %b want 00", {bus.pc_write, bus.ifid_write});
        end
        tick(2);
        checks++;
        if ({bus.pc_write, bus.ifid_write, bus.stall_cnt} !== {2'b11, 4'd2}) begin
            errors++;
            $display("FAIL raw_release got %h want %h", {bus.pc_write, bus.ifid_write, bus.stall_cnt},
                     {2'b11, 4'd2});
        end
        tick(1);
        checks++;
        if ({bus.ex_dest, bus.fwd_a, bus.fwd_b} !== {5'd6, 2'b00, 2'b00}) begin
            errors++;
            $display("FAIL raw_enter got %h want %h", {bus.ex_dest, bus.fwd_a, bus.fwd_b},
                     {5'd6, 2'b00, 2'b00});
        end
`endif
        set_id(6'h00, 5'd1, 5'd2, 5'd0, 1'b0);   // add r0,r1,r2
        tick(1);
        set_id(6'h00, 5'd0, 5'd0, 5'd3, 1'b0);   // add r3,r0,r0
        checks++;
        if ({bus.pc_write, bus.ifid_write} !== 2'b11) begin
            errors++;
            $display("FAIL r0_no_stall got %b want 11", {bus.pc_write, bus.ifid_write});
        end
        tick(1);
        checks++;
        if ({bus.ex_dest, bus.mem_dest, bus.fwd_a, bus.fwd_b} !== {5'd3, 5'd0, 2'b00, 2'b00}) begin
            errors++;
            $display("FAIL r0_no_fwd got %h want %h", {bus.ex_dest, bus.mem_dest, bus.fwd_a, bus.fwd_b},
                     {5'd3, 5'd0, 2'b00, 2'b00});
        end
    endtask

    task automatic test_branch();
        do_reset();
        set_id(6'h04, 5'd1, 5'd1, 5'd0, 1'b0);   // beq r1,r1
        tick(1);
        set_id(6'h02, 5'd0, 5'd0, 5'd0, 1'b1);   // j in ID, beq taken in EX
        checks++;
        if ({bus.pc_write, bus.ifid_flush, bus.pc_src_branch, bus.pc_src_jump} !== 4'b1110) begin
            errors++;
            $display("FAIL beq_taken got %b want 1110",
                     {bus.pc_write, bus.ifid_flush, bus.pc_src_branch, bus.pc_src_jump});
        end
        tick(1);
        checks++;
        if ({bus.ex_regdst, bus.ex_alusrc, bus.ex_aluop, bus.ex_dest, bus.flush_cnt} !== {4'b0000, 5'd0, 4'd1}) begin
            errors++;
            $display("FAIL beq_bubble got %h want %h",
                     {bus.ex_regdst, bus.ex_alusrc, bus.ex_aluop, bus.ex_dest, bus.flush_cnt}, {4'b0000, 5'd0, 4'd1});
        end
        set_id(6'h05, 5'd1, 5'd2, 5'd0, 1'b1);   // bne r1,r2
        tick(1);
        set_id(6'h08, 5'd3, 5'd7, 5'd0, 1'b1);   // addi r7; bne sees zero=1
        checks++;
        if ({bus.pc_write, bus.ifid_flush, bus.pc_src_branch, bus.pc_src_jump} !== 4'b1000) begin
            errors++;
            $display("FAIL bne_not_taken got %b want 1000",
                     {bus.pc_write, bus.ifid_flush, bus.pc_src_branch, bus.pc_src_jump});
        end
        tick(1);
        checks++;
        if ({bus.ex_regdst, bus.ex_alusrc, bus.ex_aluop, bus.ex_dest, bus.flush_cnt} !== {4'b0100, 5'd7, 4'd1}) begin
            errors++;
            $display("FAIL bne_nt_pass got %h want %h",
                     {bus.ex_regdst, bus.ex_alusrc, bus.ex_aluop, bus.ex_dest, bus.flush_cnt}, {4'b0100, 5'd7, 4'd1});
        end
        set_id(6'h05, 5'd1, 5'd2, 5'd0, 1'b0);   // bne r1,r2
        tick(1);
        set_id(6'h00, 5'd1, 5'd2, 5'd8, 1'b0);   // add r8 squashed; bne sees zero=0
        checks++;
        if ({bus.pc_write, bus.ifid_flush, bus.pc_src_branch, bus.pc_src_jump} !== 4'b1110) begin
            errors++;
            $display("FAIL bne_taken got %b want 1110",
                     {bus.pc_write, bus.ifid_flush, bus.pc_src_branch, bus.pc_src_jump});
        end
        tick(1);
        checks++;
        if ({bus.ex_regdst, bus.ex_dest, bus.flush_cnt} !== {1'b0, 5'd0, 4'd2}) begin
            errors++;
            $display("FAIL bne_squash got %h want %h", {bus.ex_regdst, bus.ex_dest, bus.flush_cnt},
                     {1'b0, 5'd0, 4'd2});
        end
    endtask

    task automatic test_jump();
        do_reset();
        set_id(6'h02, 5'd0, 5'd0, 5'd0, 1'b0);
        checks++;
        if ({bus.pc_write, bus.ifid_flush, bus.pc_src_branch, bus.pc_src_jump} !== 4'b1101) begin
            errors++;
            $display("FAIL jump_ctrl got %b want 1101",
                     {bus.pc_write, bus.ifid_flush, bus.pc_src_branch, bus.pc_src_jump});
        end
        tick(1);
        set_id(6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        checks++;
        if ({bus.ex_regdst, bus.ex_alusrc, bus.ex_aluop, bus.ex_dest, bus.flush_cnt} !== {4'b0000, 5'd0, 4'd1}) begin
            errors++;
            $display("FAIL jump_bubble got %h want %h",
                     {bus.ex_regdst, bus.ex_alusrc, bus.ex_aluop, bus.ex_dest, bus.flush_cnt}, {4'b0000, 5'd0, 4'd1});
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        set_id(6'h23, 5'd1, 5'd2, 5'd0, 1'b0);   // lw r2
        tick(1);
        set_id(6'h00, 5'd2, 5'd4, 5'd3, 1'b0);   // add r3,r2,r4
        checks++;
        if ({bus.pc_write, bus.ifid_write} !== 2'b00) begin
            errors++;
            $display("FAIL mid_stall_pre got %b want 00", {bus.pc_write, bus.ifid_write});
        end
        tick(1);
        checks++;
        if ({bus.stall_cnt, bus.mem_dest} !== {4'd1, 5'd2}) begin
            errors++;
            $display("FAIL mid_stall_cnt got %h want %h", {bus.stall_cnt, bus.mem_dest}, {4'd1, 5'd2});
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.pc_src_branch, bus.pc_src_jump} !== 5'b11000) begin
            errors++;
            $display("FAIL mid_reset_pc got %b want 11000",
                     {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.pc_src_branch, bus.pc_src_jump});
        end
        checks++;
        if ({bus.stall_cnt, bus.ex_dest, bus.mem_dest, bus.wb_dest, bus.fwd_a, bus.fwd_b} !== 23'd0) begin
            errors++;
            $display("FAIL mid_reset_state got %h want 0",
                     {bus.stall_cnt, bus.ex_dest, bus.mem_dest, bus.wb_dest, bus.fwd_a, bus.fwd_b});
        end
        #2 reset = 1'b0;
        tick(1);
        checks++;
        if ({bus.ex_regdst, bus.ex_alusrc, bus.ex_aluop, bus.ex_dest} !== {4'b1010, 5'd3}) begin
            errors++;
            $display("FAIL post_reset_decode got %h want %h",
                     {bus.ex_regdst, bus.ex_alusrc, bus.ex_aluop, bus.ex_dest}, {4'b1010, 5'd3});
        end
    endtask

    task automatic test_saturation();
        do_reset();
        set_id(6'h23, 5'd2, 5'd2, 5'd0, 1'b0);   // lw r2,0(r2) repeatedly self-dependent
        tick(4);
        checks++;
        if (bus.stall_cnt !== 4'd2) begin
            errors++;
            $display("FAIL sat_early got %0d want 2", bus.stall_cnt);
        end
        tick(56);
        checks++;
        if (bus.stall_cnt !== 4'd15) begin
            errors++;
            $display("FAIL sat_hold got %0d want 15", bus.stall_cnt);
        end
        tick(4);
        checks++;
        if (bus.stall_cnt !== 4'd15) begin
            errors++;
            $display("FAIL sat_no_wrap got %0d want 15", bus.stall_cnt);
        end
    endtask

    initial begin
        set_id(6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        test_reset();
        test_decode();
        test_load_use();
        test_forward();
        test_branch();
        test_jump();
        test_reset_mid_stall();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
